ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction-fetch front end. It reads the address produced by the program counter, issues word reads to instruction memory over a req/gnt/rvalid handshake, and buffers the returned instructions with their PCs in a small FIFO. It hands instructions to decode over a valid/ready interface.
- Holds the PC (pc_stall) while a fetch is not accepted.
- Flushes all buffered and in-flight work on a taken branch or jump (redirect).

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- XLEN, 32, width of address and instruction.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- fetch_pc  in  XLEN  current PC from the program counter.
- redirect  in  1  branch/jump taken this cycle; the program counter loads its target on this edge.
- pc_stall  out  1  high means the program counter must hold its value.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  XLEN  request address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  XLEN  read data.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode accepts the head.
- inst  out  XLEN  head instruction.
- inst_pc  out  XLEN  PC of the head instruction.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE; count = 0; read and write pointers = 0.
  - imem_req = 0, inst_valid = 0, pc_stall = 1, inst/inst_pc = 0, imem_addr = 0.
- Single outstanding request at most. Credit rule: a new request is allowed only if count + outstanding < DEPTH.
- imem_addr = {fetch_pc[XLEN-1:2], 2'b00}. The full fetch_pc is captured into a pend_pc register when the request is granted.
- FSM states and transitions:
  - IDLE: if credit available and no redirect, go to REQ.
  - REQ: imem_req = 1.
    - imem_gnt = 1: capture pend_pc, go to WAIT.
    - No gnt: stay in REQ. imem_req stays high, and imem_addr tracks fetch_pc, which is stable because the PC is stalled.
  - WAIT: on imem_rvalid, write {pend_pc, imem_rdata} to the tail.
    - If credit remains after the write, go to REQ; otherwise go to IDLE.
    - Back-to-back fetches therefore sustain one instruction per 2 cycles minimum: REQ, then WAIT with rvalid.
  - DROP: on imem_rvalid, discard the data and go to IDLE.
- pc_stall = !(imem_req && imem_gnt) && !redirect. The PC advances exactly once per granted request, or loads the target on redirect.
- Output side: inst_valid = (count != 0). The head pops when inst_valid && inst_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- redirect, which has priority over everything:
  - Count and pointers clear on the same edge.
  - inst_valid is low the next cycle, and the popped entry of that cycle is invalid. Decode ignores inst_valid during redirect.
  - FSM transitions on redirect:
    - REQ with gnt: go to DROP.
    - REQ without gnt: go to IDLE; imem_req deasserts next cycle.
    - WAIT without rvalid: go to DROP.
    - WAIT with rvalid: discard the data, go to IDLE.
    - DROP: stay in DROP, or go to IDLE if rvalid.
    - IDLE: stay in IDLE.
  - Fetching resumes from the new PC the cycle after redirect.
- A stray imem_rvalid in IDLE or REQ is ignored.
- Full queue: no request is issued, pc_stall stays high, and the queue contents hold.
- Empty queue with inst_ready high: no pop, no error.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count == 0, in WAIT, and imem_rvalid arrives without redirect, the data is forwarded combinationally: inst_valid = 1, inst = imem_rdata, inst_pc = pend_pc, all in the same cycle.
  - If inst_ready is high, nothing is written to the queue; otherwise the entry is written normally.
- Undefined: fetched data appears at the head no earlier than the cycle after rvalid.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - the fetch FSM state enum (IDLE/REQ/WAIT/DROP);
  - XLEN;
  - the fetch entry struct {pc, inst}.
- One natural sub-module: ifq_fifo, a DEPTH-entry synchronous FIFO with push, pop, flush, count, and async active-low clear. The FSM and credit logic live in ifetch_queue.

Test Plan:
- Reset:
  - Stimulus: reset low mid-WAIT, then release, with fetch_pc=0x0.
  - Response: all outputs at reset values while low; imem_req rises 1 cycle after release with imem_addr=0x0; the late rvalid is ignored.
- Streaming:
  - Stimulus: gnt tied to 1, rvalid 1 cycle after gnt, inst_ready=1, PC stepping 0x0,0x4,0x8.
  - Response: inst/inst_pc pairs appear in order; pc_stall low exactly on grant cycles.
- Backpressure:
  - Stimulus: inst_ready=0, DEPTH=4.
  - Response: exactly 4 entries are fetched, then imem_req stays 0 and pc_stall stays 1. Releasing inst_ready drains 0x0..0xC in order, then fetching resumes.
- Redirect in WAIT:
  - Stimulus: redirect while a request to 0x10 is outstanding, with the new PC 0x80.
  - Response: the response for 0x10 is dropped, the queue is empty, the next granted address is 0x80, and inst_pc of the next output is 0x80.
- Grant stall:
  - Stimulus: imem_gnt held low 5 cycles at PC 0x20.
  - Response: imem_req and imem_addr=0x20 are stable, pc_stall=1 throughout, and the PC advances only on the gnt cycle.
- Bypass (IFQ_BYPASS_EN):
  - Stimulus: empty queue, inst_ready=1, rvalid with data 0x00500093.
  - Response: inst_valid=1, inst=0x00500093 in the same cycle, and count stays 0.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path types: fetch FSM states, data width and queue entry.
// Used by ifetch_queue and ifq_fifo.
package rv_fetch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry FIFO of fetch entries with flush and async active-low clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifq_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: one outstanding imem read, credit-limited queue.
// Define IFQ_BYPASS_EN to forward a response straight to decode when empty.
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            redirect,
    output logic            pc_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    import rv_fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_state_e    state;
    logic [XLEN-1:0] pend_pc;
    logic [AW:0]     count;
    logic [AW:0]     count_after;
    fetch_entry_t    head;
    fetch_entry_t    wentry;
    logic            grant;
    logic            rsp;
    logic            has_data;
    logic            bypass;
    logic            push;
    logic            pop;

    assign imem_req  = (state == REQ);
    assign imem_addr = imem_req ? {fetch_pc[XLEN-1:2], 2'b00} : '0;
    assign grant     = imem_req && imem_gnt;
    assign pc_stall  = !grant && !redirect;
    assign rsp       = (state == WAIT) && imem_rvalid && !redirect;
    assign has_data  = (count != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp && !has_data;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid = has_data || bypass;
    assign inst    = bypass ? imem_rdata : (has_data ? head.inst : '0);
    assign inst_pc = bypass ? pend_pc : (has_data ? head.pc : '0);

    // A forwarded response that decode takes never occupies a slot.
    assign pop    = has_data && inst_ready && !redirect;
    assign push   = rsp && !(bypass && inst_ready);
    assign wentry = '{pc: pend_pc, inst: imem_rdata};

    always_comb begin
        count_after = count;
        if (push && !pop)      count_after = count + 1'b1;
        else if (pop && !push) count_after = count - 1'b1;
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            if (grant) pend_pc <= fetch_pc;
            unique case (state)
                IDLE: if (!redirect && count < FULL) state <= REQ;
                REQ: begin
                    if (redirect)   state <= grant ? DROP : IDLE;
                    else if (grant) state <= WAIT;
                end
                WAIT: begin
                    if (redirect)
                        state <= imem_rvalid ? IDLE : DROP;
                    else if (imem_rvalid)
                        state <= (count_after < FULL) ? REQ : IDLE;
                end
                DROP: if (imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-level model plus directed phases.
// Build with IFQ_BYPASS_EN to exercise the forwarding path.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        redirect;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_pc    (fetch_pc),
        .redirect    (redirect),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    int tests = 0;
    int fails = 0;

    // model: buffered entries, request line, kept / discarded outstanding read
    ent_t        q[$];
    bit          m_req, m_wait, m_drop;
    logic [31:0] m_pend;

    // environment: program counter and a one-slot memory
    logic [31:0] pc;
    bit          rp;
    int          rt;
    logic [31:0] ra;

    bit          rst_k, redir_k, gnt_k, ready_k, stray_k;
    logic [31:0] tgt_k, tgt;
    int          delay_k;

    logic [31:0] glog[$];
    logic [31:0] plog[$];
    logic [31:0] ilog[$];
    bit          byp_seen;

    function automatic logic [31:0] memw(logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic apply();
        reset = rst_k;
        if (!rst_k) begin
            q.delete();
            m_req  = 0;
            m_wait = 0;
            m_drop = 0;
            pc     = 0;
        end
        redirect    = redir_k;
        tgt         = tgt_k;
        redir_k     = 0;
        fetch_pc    = pc;
        imem_gnt    = gnt_k;
        imem_rvalid = (rp && rt == 0) || stray_k;
        imem_rdata  = (rp && rt == 0) ? memw(ra) : 32'hDEAD_BEEF;
        stray_k     = 0;
        inst_ready  = ready_k;
    endtask

    task automatic check();
        bit          grant, byp, idle, got, nreq;
        int          pre;
        logic [31:0] gaddr;
        grant = 0;
        gaddr = {pc[31:2], 2'b00};
        if (imem_req && imem_gnt) glog.push_back(imem_addr);
        if (inst_valid && inst_ready && !redirect) begin
            plog.push_back(inst_pc);
            ilog.push_back(inst);
        end
        if (rp && rt == 0 && ra == 32'h100)
            byp_seen = inst_valid && (inst == 32'h0050_0093);
        if (!reset) begin
            chk("rst_req", imem_req, 0);
            chk("rst_valid", inst_valid, 0);
            chk("rst_stall", pc_stall, 1);
            chk("rst_addr", imem_addr, 0);
            chk("rst_inst", inst, 0);
            chk("rst_pc", inst_pc, 0);
        end else begin
            byp = 0;
`ifdef IFQ_BYPASS_EN
            byp = (q.size() == 0) && m_wait && imem_rvalid && !redirect;
`endif
            grant = m_req && imem_gnt;
            chk("req", imem_req, m_req);
            if (m_req) chk("addr", imem_addr, gaddr);
            chk("stall", pc_stall, !grant && !redirect);
            chk("valid", inst_valid, (q.size() != 0) || byp);
            if (byp) begin
                chk("inst", inst, imem_rdata);
                chk("inst_pc", inst_pc, m_pend);
            end else if (q.size() != 0) begin
                chk("inst", inst, q[0].ins);
                chk("inst_pc", inst_pc, q[0].pc);
            end
            if (redirect) begin
                m_drop = grant || ((m_wait || m_drop) && !imem_rvalid);
                m_req  = 0;
                m_wait = 0;
                q.delete();
                pc = tgt;
            end else begin
                idle = !m_req && !m_wait && !m_drop;
                pre  = q.size();
                if (q.size() != 0 && inst_ready) void'(q.pop_front());
                got = m_wait && imem_rvalid;
                if (got && !(byp && inst_ready))
                    q.push_back(ent_t'{pc: m_pend, ins: imem_rdata});
                nreq = (m_req && !imem_gnt) || (idle && pre < DEPTH) ||
                       (got && q.size() < DEPTH);
                if (imem_rvalid) m_drop = 0;
                if (got) m_wait = 0;
                if (grant) begin
                    m_wait = 1;
                    m_pend = pc;
                    pc     = pc + 4;
                end
                m_req = nreq;
            end
        end
        if (rp) begin
            if (rt == 0) rp = 0;
            else rt--;
        end
        if (grant) begin
            rp = 1;
            rt = delay_k - 1;
            ra = gaddr;
        end
    endtask

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1 apply();
            @(negedge clk);
            check();
        end
    endtask

    task automatic clr();
        glog.delete();
        plog.delete();
        ilog.delete();
    endtask

    initial begin
        rst_k = 0; redir_k = 0; gnt_k = 0; ready_k = 0; stray_k = 0;
        tgt_k = 0; tgt = 0; delay_k = 3;
        pc = 0; rp = 0; rt = 0; ra = 0;
        m_req = 0; m_wait = 0; m_drop = 0; m_pend = 0;
        byp_seen = 0;
        apply();
        cyc(2);

        // reset dropped while a slow read is outstanding
        rst_k = 1; gnt_k = 1;
        cyc(2);
        chk("rst_first_grant", glog.size(), 1);
        cyc(1);
        rst_k = 0;
        cyc(1);
        rst_k = 1; delay_k = 1; ready_k = 1;
        clr();
        cyc(1);
        chk("rst_late_rvalid", inst_valid, 0);
        cyc(1);
        chk("rst_resume_req", imem_req, 1);
        chk("rst_resume_addr", imem_addr, 32'h0);

        // streaming
        cyc(10);
        chk("stream_cnt", plog.size() >= 3, 1);
        chk("stream_pc0", plog[0], 32'h0);
        chk("stream_pc1", plog[1], 32'h4);
        chk("stream_pc2", plog[2], 32'h8);
        chk("stream_ins1", ilog[1], 32'hC0DE_0004);

        // backpressure
        ready_k = 0; redir_k = 1; tgt_k = 32'h0;
        cyc(1);
        clr();
        cyc(14);
        chk("bp_grants", glog.size(), 4);
        chk("bp_g3", glog[3], 32'hC);
        chk("bp_req_low", imem_req, 0);
        chk("bp_stall", pc_stall, 1);
        chk("bp_head", inst_pc, 32'h0);
        ready_k = 1;
        cyc(6);
        chk("drain_cnt", plog.size() >= 4, 1);
        chk("drain_pc0", plog[0], 32'h0);
        chk("drain_pc1", plog[1], 32'h4);
        chk("drain_pc2", plog[2], 32'h8);
        chk("drain_pc3", plog[3], 32'hC);
        chk("resume_addr", glog[4], 32'h10);

        // redirect while a read to 0x10 is outstanding
        delay_k = 3; gnt_k = 0; redir_k = 1; tgt_k = 32'h10;
        cyc(1);
        cyc(6);
        clr();
        gnt_k = 1;
        cyc(1);
        chk("rw_grant10", glog[0], 32'h10);
        redir_k = 1; tgt_k = 32'h80;
        cyc(1);
        chk("rw_flush", inst_valid, 0);
        cyc(12);
        chk("rw_next_grant", glog[1], 32'h80);
        chk("rw_first_pc", plog[0], 32'h80);
        chk("rw_first_ins", ilog[0], 32'hC0DE_0080);

        // grant held low at 0x20, then a stray rvalid
        gnt_k = 0; delay_k = 1; redir_k = 1; tgt_k = 32'h20;
        cyc(1);
        cyc(8);
        clr();
        cyc(5);
        chk("gs_req", imem_req, 1);
        chk("gs_addr", imem_addr, 32'h20);
        chk("gs_stall", pc_stall, 1);
        chk("gs_no_grant", glog.size(), 0);
        stray_k = 1;
        cyc(1);
        cyc(1);
        chk("stray_ignored", inst_valid, 0);
        gnt_k = 1;
        cyc(1);
        chk("gs_grant", glog[0], 32'h20);
        cyc(3);
        chk("gs_pc", plog[0], 32'h20);

        // response into an empty queue with decode ready
        redir_k = 1; tgt_k = 32'h100; byp_seen = 0;
        cyc(1);
        clr();
        cyc(10);
`ifdef IFQ_BYPASS_EN
        chk("bypass_same_cycle", byp_seen, 1);
`else
        chk("bypass_same_cycle", byp_seen, 0);
`endif
        chk("byp_pc", plog[0], 32'h100);
        chk("byp_ins", ilog[0], 32'h0050_0093);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
